median_win_ctrl: RTL and testbench

//  Raster-stream scheduler for the 9-input combinational median network `sort`.

---
 rtl/median_pkg.sv | 22 ++
 rtl/median_win_ctrl_line_buf.sv | 32 +++
 rtl/median_win_ctrl_sort.sv | 33 +++
 rtl/median_win_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_median_win_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/median_pkg.sv
// Shared types and helpers for the 3x3 median window controller.
package median_pkg;

   localparam int PIX_W_DEF = 9;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   // Width of the column counter for a line of img_w pixels
   function automatic int calc_col_w(input int img_w);
      return (img_w > 1) ? $clog2(img_w) : 1;
   endfunction

   // Width of the row counter for a frame of img_h lines
   function automatic int calc_row_w(input int img_h);
      return (img_h > 1) ? $clog2(img_h) : 1;
   endfunction

endpackage

// File: rtl/median_win_ctrl_line_buf.sv
// Two-line pixel buffer for the 3x3 window. Both lines are addressed by the
// same column: a write pushes the incoming pixel into the "one line up" store
// and moves the previous content of that column into the "two lines up" store.
// Contents are never cleared; the first two rows of a frame overwrite them.
module line_buf #(
   parameter int PIX_W  = 9,
   parameter int IMG_W  = 640,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [PIX_W-1:0]  i_wdata,
   output logic [PIX_W-1:0]  o_rd_up1,
   output logic [PIX_W-1:0]  o_rd_up2
);

   logic [PIX_W-1:0] r_line_up1 [0:IMG_W-1];
   logic [PIX_W-1:0] r_line_up2 [0:IMG_W-1];

   // Shift the addressed column down by one line on every accepted pixel
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_line_up1[i_addr] <= i_wdata;
         r_line_up2[i_addr] <= r_line_up1[i_addr];
      end
   end

   assign o_rd_up1 = r_line_up1[i_addr];
   assign o_rd_up2 = r_line_up2[i_addr];

endmodule

// File: rtl/median_win_ctrl_sort.sv
// Combinational 9-input median network. An odd-even transposition sort of
// nine rounds fully orders the inputs; the middle element is the median.
// Comparisons are unsigned at full pixel width.
module sort #(
   parameter int PIX_W = 9
) (
   input  logic [9*PIX_W-1:0] i_win,
   output logic [PIX_W-1:0]   o_med
);

   // Sort the nine window pixels and pick the middle one
   always_comb begin : p_sort
      logic [PIX_W-1:0] w_s [0:8];
      logic [PIX_W-1:0] w_tmp;
      w_tmp = '0;
      for (int k = 0; k < 9; k++) begin
         w_s[k] = i_win[k*PIX_W +: PIX_W];
      end
      for (int r = 0; r < 9; r++) begin
         for (int k = 0; k < 8; k++) begin
            if (((k % 2) == (r % 2)) && (w_s[k] > w_s[k+1])) begin
               w_tmp    = w_s[k];
               w_s[k]   = w_s[k+1];
               w_s[k+1] = w_tmp;
            end else begin
               w_tmp = w_tmp;
            end
         end
      end
      o_med = w_s[4];
   end

endmodule

// File: rtl/median_win_ctrl.sv
// Raster-stream 3x3 median scheduler. Buffers two lines, builds a sliding
// window and emits one median per interior pixel over valid/ready.
// Optional build macro: MEDIAN_BYPASS_EN adds a `bypass` input that selects
// the window centre pixel instead of the median.
module median_win_ctrl
   import median_pkg::*;
#(
   parameter int PIX_W = PIX_W_DEF,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef MEDIAN_BYPASS_EN
   input  logic             bypass,
`endif
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [PIX_W-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [PIX_W-1:0] m_data,
   output logic             m_eol,
   output logic             m_last,
   output logic             busy,
   output logic             frame_done
);

   localparam int COL_W = calc_col_w(IMG_W);
   localparam int ROW_W = calc_row_w(IMG_H);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   state_t r_state;
   state_t w_state_nxt;

   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;

   logic w_s_ready;
   logic w_busy;
   logic w_frame_done;
   logic w_accept;
   logic w_col_last;
   logic w_row_last;
   logic w_frame_end;
   logic w_win_done;

   logic [PIX_W-1:0] w_up1;
   logic [PIX_W-1:0] w_up2;
   logic [PIX_W-1:0] w_med;
   logic [PIX_W-1:0] w_sel;
   logic [9*PIX_W-1:0] w_win;

   // Two older window columns: top (two lines up), mid (one up), bottom (current)
   logic [PIX_W-1:0] r_h0_t, r_h0_m, r_h0_b;
   logic [PIX_W-1:0] r_h1_t, r_h1_m, r_h1_b;

   logic             r_m_valid;
   logic [PIX_W-1:0] r_m_data;
   logic             r_m_eol;
   logic             r_m_last;

   assign w_accept    = s_valid & w_s_ready;
   assign w_col_last  = (r_col == COL_LAST);
   assign w_row_last  = (r_row == ROW_LAST);
   assign w_frame_end = w_accept & w_col_last & w_row_last;
   // The window is complete once two full columns of history exist on
   // the current line and two lines are already buffered above it.
   assign w_win_done  = w_accept & (r_col >= COL_W'(2)) & (r_row >= ROW_W'(2));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = ACTIVE;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         ACTIVE: begin
            if (w_frame_end) begin
               w_state_nxt = DRAIN;
            end else begin
               w_state_nxt = ACTIVE;
            end
         end
         DRAIN: begin
            if (r_m_valid && m_ready && r_m_last) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = DRAIN;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // FSM-derived outputs; input is stalled only when the output register is
   // full and not being drained this cycle
   always_comb begin
      w_s_ready    = 1'b0;
      w_busy       = 1'b0;
      w_frame_done = 1'b0;
      case (r_state)
         IDLE: begin
            w_s_ready = 1'b0;
            w_busy    = 1'b0;
         end
         ACTIVE: begin
            w_s_ready = ~r_m_valid | m_ready;
            w_busy    = 1'b1;
         end
         DRAIN: begin
            w_s_ready    = 1'b0;
            w_busy       = 1'b1;
            w_frame_done = r_m_valid & m_ready & r_m_last;
         end
         default: begin
            w_s_ready = 1'b0;
            w_busy    = 1'b0;
         end
      endcase
   end

   // Raster position of the next pixel to be accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if ((r_state == IDLE) && start) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         if (w_col_last) begin
            r_col <= '0;
            if (w_row_last) begin
               r_row <= '0;
            end else begin
               r_row <= r_row + ROW_W'(1);
            end
         end else begin
            r_col <= r_col + COL_W'(1);
         end
      end
   end

   line_buf #(
      .PIX_W  (PIX_W),
      .IMG_W  (IMG_W),
      .ADDR_W (COL_W)
   ) u_line_buf (
      .clk      (clk),
      .i_we     (w_accept),
      .i_addr   (r_col),
      .i_wdata  (s_data),
      .o_rd_up1 (w_up1),
      .o_rd_up2 (w_up2)
   );

   // Slide the window by one column on each accepted pixel
   always_ff @(posedge clk) begin
      if (rst) begin
         r_h0_t <= '0;
         r_h0_m <= '0;
         r_h0_b <= '0;
         r_h1_t <= '0;
         r_h1_m <= '0;
         r_h1_b <= '0;
      end else if (w_accept) begin
         r_h0_t <= r_h1_t;
         r_h0_m <= r_h1_m;
         r_h0_b <= r_h1_b;
         r_h1_t <= w_up2;
         r_h1_m <= w_up1;
         r_h1_b <= s_data;
      end
   end

   // Window presented to the median network: two history columns plus the
   // column being completed by the incoming pixel
   assign w_win = {r_h0_t, r_h0_m, r_h0_b,
                   r_h1_t, r_h1_m, r_h1_b,
                   w_up2,  w_up1,  s_data};

   sort #(
      .PIX_W (PIX_W)
   ) u_sort (
      .i_win (w_win),
      .o_med (w_med)
   );

`ifdef MEDIAN_BYPASS_EN
   assign w_sel = bypass ? r_h1_m : w_med;
`else
   assign w_sel = w_med;
`endif

   // Single output register: load on a new window, clear when drained
   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_m_eol   <= 1'b0;
         r_m_last  <= 1'b0;
      end else if (w_win_done) begin
         r_m_valid <= 1'b1;
         r_m_data  <= w_sel;
         r_m_eol   <= w_col_last;
         r_m_last  <= w_col_last & w_row_last;
      end else if (m_ready) begin
         r_m_valid <= 1'b0;
      end
   end

   assign s_ready    = w_s_ready;
   assign busy       = w_busy;
   assign frame_done = w_frame_done;
   assign m_valid    = r_m_valid;
   assign m_data     = r_m_data;
   assign m_eol      = r_m_eol;
   assign m_last     = r_m_last;

endmodule

// File: tb/tb_median_win_ctrl.sv
// Scoreboard bench for median_win_ctrl on a 5x4 image (6 medians per frame).
module tb_median_win_ctrl;

   localparam int PIX_W = 9;
   localparam int IMG_W = 5;
   localparam int IMG_H = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             s_valid;
   logic             s_ready;
   logic [PIX_W-1:0] s_data;
   logic             m_valid;
   logic             m_ready;
   logic [PIX_W-1:0] m_data;
   logic             m_eol;
   logic             m_last;
   logic             busy;
   logic             frame_done;
`ifdef MEDIAN_BYPASS_EN
   logic             bypass;
`endif

   typedef struct {
      int data;
      bit eol;
      bit last;
   } exp_t;

   exp_t q[$];
   int   img [0:IMG_H-1][0:IMG_W-1];
   int   out_log [0:7];
   int   out_cnt = 0;
   bit   byp_mode = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   median_win_ctrl #(
      .PIX_W (PIX_W),
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
`ifdef MEDIAN_BYPASS_EN
      .bypass     (bypass),
`endif
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_eol      (m_eol),
      .m_last     (m_last),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Median by rank counting over the 3x3 neighbourhood centred at (r,c)
   function automatic int model_med(input int r, input int c);
      int v [0:8];
      int k;
      int lt;
      int eq;
      k = 0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            v[k] = img[r+dr][c+dc];
            k++;
         end
      end
      for (int i = 0; i < 9; i++) begin
         lt = 0;
         eq = 0;
         for (int j = 0; j < 9; j++) begin
            if (v[j] < v[i]) lt++;
            else if (v[j] == v[i]) eq++;
         end
         if (lt <= 4 && (lt + eq) >= 5) return v[i];
      end
      return -1;
   endfunction

   // Output monitor, sampled mid low phase
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (m_valid && m_ready) begin
         if (q.size() == 0) begin
            check_val("spurious_out", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            check_val("m_data", m_data, e.data);
            check_val("m_eol", m_eol, e.eol);
            check_val("m_last", m_last, e.last);
            check_val("frame_done", frame_done, e.last);
            if (out_cnt < 8) out_log[out_cnt] = m_data;
            out_cnt++;
         end
      end else if (m_valid && !m_ready) begin
         if (q.size() > 0) check_val("hold_data", m_data, q[0].data);
         check_val("s_ready_bp", s_ready, 32'd0);
      end
   end

   task automatic send_px(input int r, input int c);
      exp_t e;
      int n;
      s_valid = 1'b1;
      s_data  = PIX_W'(img[r][c]);
`ifdef MEDIAN_BYPASS_EN
      bypass  = byp_mode;
`endif
      if (r >= 2 && c >= 2) begin
         e.data = byp_mode ? img[r-1][c-1] : model_med(r-1, c-1);
         e.eol  = (c == IMG_W-1);
         e.last = (c == IMG_W-1) && (r == IMG_H-1);
         q.push_back(e);
      end
      n = 0;
      #1;
      while (!s_ready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!s_ready) check_val("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic build_img(input int kind);
      for (int r = 0; r < IMG_H; r++)
         for (int c = 0; c < IMG_W; c++)
            img[r][c] = (kind == 0) ? (5*r + c) : 10;
      if (kind == 1) img[1][1] = 511;
   endtask

   task automatic start_frame();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("busy_start", busy, 32'd1);
      out_cnt = 0;
   endtask

   task automatic run_frame(input int kind, input bit byp, input bit bp);
      int n;
      build_img(kind);
      byp_mode = byp;
      start_frame();
      fork
         begin
            for (int r = 0; r < IMG_H; r++)
               for (int c = 0; c < IMG_W; c++)
                  send_px(r, c);
         end
         begin
            if (bp) begin
               repeat (13) @(negedge clk);
               m_ready = 1'b0;
               repeat (5) @(negedge clk);
               m_ready = 1'b1;
            end
         end
      join
      n = 0;
      while ((busy || q.size() > 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_val("frame_timeout", (n < 100), 32'd1);
      check_val("busy_end", busy, 32'd0);
      check_val("out_cnt", out_cnt, 32'd6);
   endtask

   task automatic check_ramp_log(input string tag);
      int ramp_exp [0:5];
      ramp_exp = '{6, 7, 8, 11, 12, 13};
      for (int i = 0; i < 6; i++) check_val(tag, out_log[i], ramp_exp[i]);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b1;
`ifdef MEDIAN_BYPASS_EN
      bypass  = 1'b0;
`endif
      // 1: reset state and no accept without start
      repeat (2) @(negedge clk);
      check_val("rst_m_valid", m_valid, 32'd0);
      check_val("rst_s_ready", s_ready, 32'd0);
      check_val("rst_busy", busy, 32'd0);
      check_val("rst_frame_done", frame_done, 32'd0);
      rst = 1'b0;
      s_valid = 1'b1;
      s_data  = 9'd77;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("idle_s_ready", s_ready, 32'd0);
         check_val("idle_busy", busy, 32'd0);
      end
      s_valid = 1'b0;

      // 2: ramp frame
      run_frame(0, 1'b0, 1'b0);
      check_ramp_log("ramp_seq");

      // 3: impulse frame
      run_frame(1, 1'b0, 1'b0);

      // 4: backpressure mid-frame
      run_frame(0, 1'b0, 1'b1);
      check_ramp_log("bp_seq");

      // 5: reset mid-frame then a full ramp frame
      build_img(0);
      start_frame();
      for (int p = 0; p < 12; p++) send_px(p / IMG_W, p % IMG_W);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      check_val("abort_m_valid", m_valid, 32'd0);
      check_val("abort_busy", busy, 32'd0);
      check_val("abort_s_ready", s_ready, 32'd0);
      run_frame(0, 1'b0, 1'b0);
      check_ramp_log("post_rst_seq");

`ifdef MEDIAN_BYPASS_EN
      // 6: bypass selects the centre pixel
      run_frame(1, 1'b1, 1'b0);
      check_val("bypass_first", out_log[0], 32'd511);
      run_frame(1, 1'b0, 1'b0);
      check_val("median_first", out_log[0], 32'd10);
`endif

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
